// File: rtl/wb_writeback_ctrl.sv
// Writeback controller: arbitrates load returns and ALU results onto the
// single register-file write port, with an in-order ALU overflow FIFO.
module wb_writeback_ctrl #(
  parameter  int DEPTH = 4,
  parameter  int AW    = 3,
  parameter  int DW    = 16,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst,
  input  logic            alu_vld_i,
  input  logic [AW-1:0]   alu_adr_i,
  input  logic [DW-1:0]   alu_data_i,
  output logic            alu_rdy_o,
  input  logic            mem_vld_i,
  input  logic [AW-1:0]   mem_adr_i,
  input  logic [DW-1:0]   mem_data_i,
  output logic            wr_ena_o,
  output logic [AW-1:0]   wr_adr_o,
  output logic [DW-1:0]   wr_data_o,
  input  logic            flag_vld_i,
  input  logic            flag_ravno_i,
  input  logic            flag_bolshe_i,
  input  logic            flag_menshe_i,
  input  logic            ra_vld_i,
  input  logic            rav_adr_i,
  output logic            flag_ena_o,
  output logic            flag_ravno_o,
  output logic            flag_bolshe_o,
  output logic            flag_menshe_o,
  output logic            flag_ena_ra_o,
  output logic            rav_adr_o,
  output logic [2**AW-1:0] busy_o,
  output logic [CW-1:0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] fa_q [DEPTH];
  logic [DW-1:0] fd_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] wp_q, wp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          ena_q, ena_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] dat_q, dat_d;

  logic          fe_q, fr_q, fb_q, fm_q;
  logic          fera_q, frav_q;

  logic          acc;
  logic          empty;
  logic          push;
  logic          pop;
  logic [PW-1:0] off;

  assign alu_rdy_o = cnt_q < CW'(DEPTH);
  assign acc       = alu_vld_i && alu_rdy_o;
  assign empty     = cnt_q == '0;

  // Load returns can never stall, so they always win the write port.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    ena_d = 1'b0;
    adr_d = adr_q;
    dat_d = dat_q;
    priority case (1'b1)
      mem_vld_i: begin
        ena_d = 1'b1;
        adr_d = mem_adr_i;
        dat_d = mem_data_i;
        push  = acc;
      end
      !empty: begin
        ena_d = 1'b1;
        adr_d = fa_q[rd_q];
        dat_d = fd_q[rd_q];
        pop   = 1'b1;
        push  = acc;
      end
      acc: begin
        ena_d = 1'b1;
        adr_d = alu_adr_i;
        dat_d = alu_data_i;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_d  = pop  ? rd_q + 1'b1 : rd_q;
    wp_d  = push ? wp_q + 1'b1 : wp_q;
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wp_q  <= '0;
      cnt_q <= '0;
      ena_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fa_q[i] <= '0;
        fd_q[i] <= '0;
      end
    end else begin
      rd_q  <= rd_d;
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      ena_q <= ena_d;
      adr_q <= adr_d;
      dat_q <= dat_d;
      if (push) begin
        fa_q[wp_q] <= alu_adr_i;
        fd_q[wp_q] <= alu_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      fe_q   <= 1'b0;
      fr_q   <= 1'b0;
      fb_q   <= 1'b0;
      fm_q   <= 1'b0;
      fera_q <= 1'b0;
      frav_q <= 1'b0;
    end else begin
      fe_q   <= flag_vld_i;
      fera_q <= ra_vld_i;
      if (flag_vld_i) begin
        fr_q <= flag_ravno_i;
        fb_q <= flag_bolshe_i;
        fm_q <= flag_menshe_i;
      end
      if (ra_vld_i) frav_q <= rav_adr_i;
    end
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    busy_o = '0;
    off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = PW'(i) - rd_q;
      if (CW'(off) < cnt_q) busy_o[fa_q[i]] = 1'b1;
    end
    if (ena_q) busy_o[adr_q] = 1'b1;
  end

  assign wr_ena_o      = ena_q;
  assign wr_adr_o      = adr_q;
  assign wr_data_o     = dat_q;
  assign flag_ena_o    = fe_q;
  assign flag_ravno_o  = fr_q;
  assign flag_bolshe_o = fb_q;
  assign flag_menshe_o = fm_q;
  assign flag_ena_ra_o = fera_q;
  assign rav_adr_o     = frav_q;
  assign count_o       = cnt_q;

endmodule

// File: tb/tb_wb_writeback_ctrl.sv
// Bench for wb_writeback_ctrl: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_wb_writeback_ctrl;

  localparam int DEPTH = 4;
  localparam int AW    = 3;
  localparam int DW    = 16;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk, rst;
  logic alu_vld, mem_vld;
  logic [AW-1:0] alu_adr, mem_adr;
  logic [DW-1:0] alu_data, mem_data;
  logic alu_rdy, wr_ena;
  logic [AW-1:0] wr_adr;
  logic [DW-1:0] wr_data;
  logic fv, fr, fb, fm, rv, ra;
  logic fe_o, fr_o, fb_o, fm_o, fera_o, rav_o;
  logic [7:0] busy;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  ent_t q[$];
  logic exp_ena;
  logic [AW-1:0] exp_adr;
  logic [DW-1:0] exp_data;
  logic exp_fe, exp_fr, exp_fb, exp_fm, exp_fera, exp_rav;

  wb_writeback_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i(clk), .rst(rst),
    .alu_vld_i(alu_vld), .alu_adr_i(alu_adr), .alu_data_i(alu_data),
    .alu_rdy_o(alu_rdy),
    .mem_vld_i(mem_vld), .mem_adr_i(mem_adr), .mem_data_i(mem_data),
    .wr_ena_o(wr_ena), .wr_adr_o(wr_adr), .wr_data_o(wr_data),
    .flag_vld_i(fv), .flag_ravno_i(fr), .flag_bolshe_i(fb),
    .flag_menshe_i(fm), .ra_vld_i(rv), .rav_adr_i(ra),
    .flag_ena_o(fe_o), .flag_ravno_o(fr_o), .flag_bolshe_o(fb_o),
    .flag_menshe_o(fm_o), .flag_ena_ra_o(fera_o), .rav_adr_o(rav_o),
    .busy_o(busy), .count_o(count)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic idle();
    alu_vld = 0; alu_adr = 0; alu_data = 0;
    mem_vld = 0; mem_adr = 0; mem_data = 0;
    fv = 0; fr = 0; fb = 0; fm = 0; rv = 0; ra = 0;
  endtask

  task automatic model_clear();
    q.delete();
    exp_ena = 0; exp_adr = 0; exp_data = 0;
    exp_fe = 0; exp_fr = 0; exp_fb = 0; exp_fm = 0;
    exp_fera = 0; exp_rav = 0;
  endtask

  // Reference: loads always win; ALU results drain in acceptance order.
  task automatic model_step();
    ent_t e;
    bit take;
    take = alu_vld && (q.size() < DEPTH);
    exp_ena = 0;
    if (mem_vld) begin
      exp_ena = 1; exp_adr = mem_adr; exp_data = mem_data;
      if (take) q.push_back('{a: alu_adr, d: alu_data});
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_ena = 1; exp_adr = e.a; exp_data = e.d;
      if (take) q.push_back('{a: alu_adr, d: alu_data});
    end else if (take) begin
      exp_ena = 1; exp_adr = alu_adr; exp_data = alu_data;
    end
    exp_fe = fv;
    if (fv) begin exp_fr = fr; exp_fb = fb; exp_fm = fm; end
    exp_fera = rv;
    if (rv) exp_rav = ra;
  endtask

  function automatic logic [7:0] exp_busy();
    logic [7:0] b = '0;
    foreach (q[i]) b[q[i].a] = 1'b1;
    if (exp_ena) b[exp_adr] = 1'b1;
    return b;
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    model_clear();
    #12;
    checks++;
    if ({wr_ena, wr_adr, wr_data} !== '0) begin
      errors++;
      $display("FAIL reset_wr: got %b/%h/%h want 0", wr_ena, wr_adr, wr_data);
    end
    checks++;
    if (busy !== 8'h00 || count !== 3'd0) begin
      errors++;
      $display("FAIL reset_busy_count: got %h/%0d want 0/0", busy, count);
    end
    checks++;
    if ({fe_o, fr_o, fb_o, fm_o, fera_o, rav_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {fe_o, fr_o, fb_o, fm_o, fera_o, rav_o});
    end
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    checks++;
    if (alu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy: got %b want 1", alu_rdy);
    end
  endtask

  task automatic test_alu_only();
    idle();
    alu_vld = 1; alu_adr = 3; alu_data = 16'h1234;
    cyc();
    idle();
    checks++;
    if (wr_ena !== 1 || wr_adr !== 3'd3 || wr_data !== 16'h1234) begin
      errors++;
      $display("FAIL alu_only_wr: got %b/%h/%h want 1/3/1234",
               wr_ena, wr_adr, wr_data);
    end
    checks++;
    if (busy !== 8'h08) begin
      errors++;
      $display("FAIL alu_only_busy: got %h want 08", busy);
    end
    cyc();
    checks++;
    if (wr_ena !== 0 || busy !== 8'h00) begin
      errors++;
      $display("FAIL alu_only_after: got ena %b busy %h want 0/00", wr_ena, busy);
    end
  endtask

  task automatic test_collision();
    idle();
    mem_vld = 1; mem_adr = 2; mem_data = 16'hAAAA;
    alu_vld = 1; alu_adr = 2; alu_data = 16'h5555;
    cyc();
    idle();
    checks++;
    if (wr_ena !== 1 || wr_adr !== 3'd2 || wr_data !== 16'hAAAA) begin
      errors++;
      $display("FAIL collision_mem: got %b/%h/%h want 1/2/aaaa",
               wr_ena, wr_adr, wr_data);
    end
    checks++;
    if (count !== 3'd1 || busy !== 8'h04) begin
      errors++;
      $display("FAIL collision_count: got %0d/%h want 1/04", count, busy);
    end
    cyc();
    checks++;
    if (wr_ena !== 1 || wr_adr !== 3'd2 || wr_data !== 16'h5555) begin
      errors++;
      $display("FAIL collision_alu: got %b/%h/%h want 1/2/5555",
               wr_ena, wr_adr, wr_data);
    end
    cyc();
  endtask

  task automatic test_full();
    int idx = 0;
    bit pre;
    ent_t obs[$];
    idle();
    for (int c = 0; c < 6; c++) begin
      mem_vld = 1; mem_adr = 7; mem_data = 16'hE000 + 16'(c);
      alu_vld = 1; alu_adr = 3'(idx); alu_data = 16'h0100 + 16'(idx);
      pre = alu_rdy;
      cyc();
      if (pre) idx++;
    end
    checks++;
    if (idx != 4 || alu_rdy !== 1'b0 || count !== 3'd4) begin
      errors++;
      $display("FAIL full_stall: accepted %0d rdy %b count %0d want 4/0/4",
               idx, alu_rdy, count);
    end
    mem_vld = 0;
    for (int c = 0; c < 20; c++) begin
      alu_vld = (idx < 6);
      alu_adr = 3'(idx); alu_data = 16'h0100 + 16'(idx);
      pre = alu_rdy && alu_vld;
      cyc();
      if (pre) idx++;
      if (wr_ena && wr_adr != 3'd7) obs.push_back('{a: wr_adr, d: wr_data});
    end
    idle();
    checks++;
    if (obs.size() != 6) begin
      errors++;
      $display("FAIL full_count: got %0d writes want 6", obs.size());
    end
    for (int k = 0; k < obs.size() && k < 6; k++) begin
      checks++;
      if (obs[k].a !== 3'(k) || obs[k].d !== 16'h0100 + 16'(k)) begin
        errors++;
        $display("FAIL full_order[%0d]: got r%0d=%h want r%0d=%h",
                 k, obs[k].a, obs[k].d, k, 16'h0100 + 16'(k));
      end
    end
  endtask

  task automatic test_flags();
    idle();
    fv = 1; fr = 1; fb = 0; fm = 0; rv = 1; ra = 1;
    cyc();
    fv = 0; fr = 0; fb = 1; fm = 1; rv = 0; ra = 0;
    checks++;
    if ({fe_o, fera_o, fr_o, fb_o, fm_o, rav_o} !== 6'b111001) begin
      errors++;
      $display("FAIL flags_capture: got %b want 111001",
               {fe_o, fera_o, fr_o, fb_o, fm_o, rav_o});
    end
    cyc();
    checks++;
    if ({fe_o, fera_o, fr_o, fb_o, fm_o, rav_o} !== 6'b001001) begin
      errors++;
      $display("FAIL flags_hold: got %b want 001001",
               {fe_o, fera_o, fr_o, fb_o, fm_o, rav_o});
    end
    idle();
  endtask

  task automatic test_reset_midop();
    idle();
    for (int c = 0; c < 3; c++) begin
      mem_vld = 1; mem_adr = 7; mem_data = 16'hBEEF;
      alu_vld = 1; alu_adr = 3'(c + 1); alu_data = 16'h0F00 + 16'(c);
      cyc();
    end
    idle();
    checks++;
    if (count !== 3'd3) begin
      errors++;
      $display("FAIL midop_fill: got count %0d want 3", count);
    end
    #3;
    rst = 1;
    model_clear();
    #1;
    checks++;
    if (count !== 3'd0 || busy !== 8'h00 || wr_ena !== 1'b0) begin
      errors++;
      $display("FAIL midop_reset: got %0d/%h/%b want 0/00/0", count, busy, wr_ena);
    end
    @(posedge clk);
    #1;
    rst = 0;
    #1;
    checks++;
    if (alu_rdy !== 1'b1) begin
      errors++;
      $display("FAIL midop_rdy: got %b want 1", alu_rdy);
    end
    for (int c = 0; c < 5; c++) begin
      cyc();
      checks++;
      if (wr_ena !== 1'b0) begin
        errors++;
        $display("FAIL midop_stale[%0d]: got write r%0d=%h want none",
                 c, wr_adr, wr_data);
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    idle();
    mem_vld = 1; mem_adr = 7; mem_data = 16'h7777;
    alu_vld = 1; alu_adr = 1; alu_data = 16'h2000;
    cyc();
    pa = 1; pd = 16'h2000;
    mem_vld = 0;
    for (int k = 0; k < 10; k++) begin
      alu_adr = 3'(k); alu_data = 16'h3000 + 16'(k);
      cyc();
      checks++;
      if (wr_ena !== 1 || wr_adr !== pa || wr_data !== pd || count !== 3'd1) begin
        errors++;
        $display("FAIL wrap[%0d]: got %b r%0d=%h cnt %0d want 1 r%0d=%h cnt 1",
                 k, wr_ena, wr_adr, wr_data, count, pa, pd);
      end
      pa = alu_adr; pd = alu_data;
    end
    idle();
    cyc();
    checks++;
    if (wr_ena !== 1 || wr_adr !== pa || wr_data !== pd || count !== 3'd0) begin
      errors++;
      $display("FAIL wrap_drain: got %b r%0d=%h cnt %0d want 1 r%0d=%h cnt 0",
               wr_ena, wr_adr, wr_data, count, pa, pd);
    end
    cyc();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (!(alu_vld && !alu_rdy) || ($urandom_range(0, 7) == 0)) begin
        alu_vld  = ($urandom_range(0, 3) != 0);
        alu_adr  = 3'($urandom);
        alu_data = 16'($urandom);
      end
      mem_vld  = ($urandom_range(0, 2) == 0);
      mem_adr  = 3'($urandom);
      mem_data = 16'($urandom);
      fv = 1'($urandom); fr = 1'($urandom); fb = 1'($urandom);
      fm = 1'($urandom); rv = 1'($urandom); ra = 1'($urandom);
      checks++;
      if (alu_rdy !== (q.size() < DEPTH)) begin
        errors++;
        $display("FAIL rnd_rdy[%0d]: got %b want %b", n, alu_rdy, q.size() < DEPTH);
      end
      cyc();
      checks++;
      if (wr_ena !== exp_ena ||
          (exp_ena && (wr_adr !== exp_adr || wr_data !== exp_data))) begin
        errors++;
        $display("FAIL rnd_wr[%0d]: got %b r%0d=%h want %b r%0d=%h",
                 n, wr_ena, wr_adr, wr_data, exp_ena, exp_adr, exp_data);
      end
      checks++;
      if (count !== 3'(q.size()) || busy !== exp_busy()) begin
        errors++;
        $display("FAIL rnd_state[%0d]: got cnt %0d busy %h want %0d/%h",
                 n, count, busy, q.size(), exp_busy());
      end
      checks++;
      if ({fe_o, fr_o, fb_o, fm_o, fera_o, rav_o} !==
          {exp_fe, exp_fr, exp_fb, exp_fm, exp_fera, exp_rav}) begin
        errors++;
        $display("FAIL rnd_flags[%0d]: got %b want %b", n,
                 {fe_o, fr_o, fb_o, fm_o, fera_o, rav_o},
                 {exp_fe, exp_fr, exp_fb, exp_fm, exp_fera, exp_rav});
      end
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_alu_only();
    test_collision();
    test_full();
    test_flags();
    test_reset_midop();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
